// File: rtl/flappy_pkg.sv
// Shared types and defaults for the FlappyBird game sequencer.
// Holds the game state encoding, score width and timing defaults.
package flappy_pkg;

   localparam int unsigned SCORE_W         = 7;
   localparam int unsigned TICK_DIV_DEF    = 4166666;
   localparam int unsigned DEATH_TICKS_DEF = 24;

   typedef enum logic [2:0] {
      READY = 3'd0,
      START = 3'd1,
      PLAY  = 3'd2,
      DYING = 3'd3,
      OVER  = 3'd4
   } game_state_t;

endpackage

// File: rtl/flappy_game_ctrl_if.sv
// Game sequencer bundle: button/collision inputs and control outputs.
// master = sequencer side (drives controls), slave = game datapath side.
interface flappy_game_ctrl_if;
   import flappy_pkg::*;

   logic               flap;
   logic               game_over;
   logic [SCORE_W-1:0] score;
   logic               game_clr;
   logic               run_en;
   logic               frame_tick;
   logic               step;
   logic               flap_pulse;
   logic [2:0]         state;
   logic [SCORE_W-1:0] high_score;

   modport master (
      input  flap, game_over, score,
      output game_clr, run_en, frame_tick, step,
      output flap_pulse, state, high_score
   );

   modport slave (
      output flap, game_over, score,
      input  game_clr, run_en, frame_tick, step,
      input  flap_pulse, state, high_score
   );

endinterface

// File: rtl/flappy_game_ctrl_tick_gen.sv
// Free-running frame divider: tick is high for one cycle after the count
// reaches DIV-1. Ports: clk, reset (async active-low), tick.
module tick_gen #(
   parameter int unsigned DIV = 4
) (
   input  logic clk,
   input  logic reset,
   output logic tick
);

   localparam int unsigned W = (DIV > 2) ? $clog2(DIV) : 1;
   localparam logic [W-1:0] LAST = W'(DIV - 1);

   logic [W-1:0] cnt_q, cnt_d;
   logic         tick_q, tick_d;

   always_comb begin
      cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
      tick_d = (cnt_q == LAST);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= tick_d;
      end
   end

   assign tick = tick_q;

endmodule

// File: rtl/flappy_game_ctrl.sv
// FlappyBird game sequencer: start/flap/restart FSM, run gating, high score.
// Ports: clk, reset (async active-low), bus (flappy_game_ctrl_if.master).
// Optional FLAPPY_HIGHSCORE_EN builds the session high-score register.
module flappy_game_ctrl
   import flappy_pkg::*;
#(
   parameter int unsigned TICK_DIV    = TICK_DIV_DEF,
   parameter int unsigned DEATH_TICKS = DEATH_TICKS_DEF
) (
   input  logic               clk,
   input  logic               reset,
   flappy_game_ctrl_if.master bus
);

   game_state_t state_q, state_d;
   logic [7:0]  death_cnt_q, death_cnt_d;
   logic        flap_q;
   logic        game_clr_q, game_clr_d;
   logic        run_en_q, run_en_d;
   logic        flap_pulse_q, flap_pulse_d;
   logic        frame_tick;
   logic        rise;

   tick_gen #(.DIV(TICK_DIV)) u_tick (
      .clk   (clk),
      .reset (reset),
      .tick  (frame_tick)
   );

   assign rise = bus.flap & ~flap_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= READY;
         death_cnt_q  <= '0;
         flap_q       <= 1'b0;
         game_clr_q   <= 1'b0;
         run_en_q     <= 1'b0;
         flap_pulse_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         death_cnt_q  <= death_cnt_d;
         flap_q       <= bus.flap;
         game_clr_q   <= game_clr_d;
         run_en_q     <= run_en_d;
         flap_pulse_q <= flap_pulse_d;
      end
   end

   // Zero check precedes the decrement, so DEATH_TICKS=0 is one cycle.
   always_comb begin
      state_d     = state_q;
      death_cnt_d = death_cnt_q;
      unique case (state_q)
         READY: if (rise) state_d = START;
         START: state_d = PLAY;
         PLAY: begin
            if (bus.game_over) begin
               state_d     = DYING;
               death_cnt_d = 8'(DEATH_TICKS);
            end
         end
         DYING: begin
            if (death_cnt_q == 8'd0)
               state_d = OVER;
            else if (frame_tick)
               death_cnt_d = death_cnt_q - 8'd1;
         end
         OVER: if (rise) state_d = START;
         default: state_d = READY;
      endcase
   end

   // Outputs are decoded from the next state so they line up with it.
   always_comb begin
      game_clr_d   = (state_d == START);
      run_en_d     = (state_d == PLAY);
      flap_pulse_d = (state_q == PLAY) & rise & ~bus.game_over;
   end

`ifdef FLAPPY_HIGHSCORE_EN
   logic [SCORE_W-1:0] high_score_q, high_score_d;

   always_comb begin
      high_score_d = high_score_q;
      if (state_q == DYING && state_d == OVER &&
          bus.score > high_score_q)
         high_score_d = bus.score;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) high_score_q <= '0;
      else        high_score_q <= high_score_d;
   end

   assign bus.high_score = high_score_q;
`else
   logic unused_score;
   assign unused_score   = ^bus.score;
   assign bus.high_score = '0;
`endif

   assign bus.game_clr   = game_clr_q;
   assign bus.run_en     = run_en_q;
   assign bus.frame_tick = frame_tick;
   assign bus.step       = frame_tick & run_en_q;
   assign bus.flap_pulse = flap_pulse_q;
   assign bus.state      = state_q;

endmodule

// File: doc/flappy_game_ctrl.md
# flappy_game_ctrl

Top-level game sequencer for FlappyBird. Turns the player's button into start, flap and restart events, and generates the frame tick. It gates the bird/pipe datapath with a run enable, clears the collision/score block at the start of every round, and freezes play when that block raises `game_over`. It sits between the input conditioning and the collision, bird and pipe blocks, and keeps the session high score.

## Interface
- `TICK_DIV`, default 4166666: `clk` cycles per frame tick (12 Hz at 50 MHz). Must be ≥ 2.
- `DEATH_TICKS`, default 24: frame ticks spent frozen in DYING before OVER. Range 0–255.
- `clk`  input  1  system clock; single clock domain.
- `reset`  input  1  asynchronous, active-low reset (asserted at 0).
- `flap`  input  1  button level, already synchronised to `clk`.
- `game_over`  input  1  collision flag from the collision/score block.
- `score`  input  7  current score from the collision/score block.
- `game_clr`  output  1  one-cycle active-high clear to the collision/score block, pipes and bird.
- `run_en`  output  1  high while the datapath may advance.
- `frame_tick`  output  1  one-cycle pulse every `TICK_DIV` cycles; free-running.
- `step`  output  1  `frame_tick & run_en`; advances bird and pipes.
- `flap_pulse`  output  1  one-cycle flap command to the bird physics.
- `state`  output  3  current state encoding, used by the display.
- `high_score`  output  7  best score this session.

## Operation
- Flap edge detect: `flap_q` holds the previous `flap`; a rise is `flap & ~flap_q`.
- READY (reset state): `run_en` = 0. A rise moves to START.
- START: lasts exactly one cycle with `game_clr` = 1, then moves to PLAY.
- PLAY: `run_en` = 1.
  - A rise makes `flap_pulse` = 1 on the next cycle.
  - `game_over` = 1 moves to DYING and loads `death_cnt` = `DEATH_TICKS`.
  - If a rise and `game_over` occur in the same cycle, `game_over` wins and no `flap_pulse` is issued.
- DYING: `run_en` = 0.
  - Each `frame_tick` decrements `death_cnt`.
  - When `death_cnt` = 0, the block moves to OVER; the check is made before the decrement, so `DEATH_TICKS` = 0 gives a one-cycle DYING.
  - Rises are ignored.
- OVER: `run_en` = 0. A rise moves to START (restart).
- High score:
  - Updated on the DYING→OVER transition if `score > high_score` (unsigned 7-bit compare).
  - It never decreases and is cleared only by reset.
- `flap` held high across a state change produces no new rise; the player must release and press again.

## Timing
- Reset values: state = READY, `game_clr` = 0, `run_en` = 0, `frame_tick` = 0, `step` = 0, `flap_pulse` = 0, `high_score` = 0, tick counter = 0, `death_cnt` = 0.
- All outputs are registered except `step`, which is the AND of two registered signals.
- Rise on `flap` at cycle n, in READY or OVER: state = START at n+1 (`game_clr` = 1), PLAY at n+2 (`run_en` = 1).
- `game_over` sampled high at cycle n in PLAY: `run_en` = 0 at n+1.
- Tick counter:
  - Counts 0…`TICK_DIV`−1 and wraps to 0.
  - `frame_tick` is high in the cycle after the count reaches `TICK_DIV`−1.
  - It is never reset by state changes.
- Reset asserted mid-game (any state): all outputs return to reset values immediately, asynchronously. `high_score` is lost.

## Configuration
- `FLAPPY_HIGHSCORE_EN` defined: high-score register and compare as described above.
- Not defined: no register is built and `high_score` is tied to 0.

## Structure
- Shared package `flappy_pkg` holds:
  - state enum `game_state_t` (READY, START, PLAY, DYING, OVER);
  - `SCORE_W` = 7;
  - default `TICK_DIV` and `DEATH_TICKS`.
- One sub-module, `tick_gen`: parameterised divider producing `frame_tick`. The FSM and high-score logic live in the top.

## Test plan
- Reset then idle; sim `TICK_DIV` = 4, `DEATH_TICKS` = 2 → state READY, `run_en` = 0, `frame_tick` pulses every 4 cycles, `step` = 0.
- Raise `flap` → `game_clr` high exactly 1 cycle; PLAY next; `step` = `frame_tick`.
- In PLAY, three separate 1→0 presses → exactly three `flap_pulse` pulses; holding `flap` high for 10 cycles → one pulse.
- `score` = 5 while `game_over` rises together with a `flap` rise → no `flap_pulse`, DYING, OVER after 2 ticks, `high_score` = 5. A second round with `score` = 3 → `high_score` stays 5.
- Drop `reset` low during PLAY mid-tick → all outputs 0 and state READY without waiting for a clock edge.
- Build without `FLAPPY_HIGHSCORE_EN`, repeat the score-5 round → `high_score` = 0.
